// File: rtl/rd_fetch_pkg.sv
// Shared types and constants for the MCB read-line fetcher.
// Holds the FSM state encoding, the read command opcode and the read-start threshold helper.
package rd_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CMD,
        ST_DATA,
        ST_GAP
    } state_e;

    localparam logic [2:0] MCB_CMD_READ = 3'b011;
    localparam int         RD_THRESH    = 8;

    // Short bursts never reach RD_THRESH words, so the threshold caps at the burst size.
    function automatic logic [6:0] rd_threshold(input logic [5:0] bl);
        logic [6:0] words;
        words = {1'b0, bl} + 7'd1;
        return (words < 7'(RD_THRESH)) ? words : 7'(RD_THRESH);
    endfunction

endpackage

// File: rtl/rd_fetch_addr.sv
// Line counter, burst index and column offset generation for rd_line_fetch.
// The column is accumulated by stride per burst, equivalent to burst_idx*stride modulo 2^COL_BITS.
module rd_fetch_addr
    import rd_fetch_pkg::*;
#(
    parameter int LINE_BITS = 11,
    parameter int COL_BITS  = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_burst,
    input  logic                 burst_end,
    input  logic                 line_end,
    input  logic                 vs_sync,
    input  logic [COL_BITS-1:0]  cfg_stride,
    input  logic [LINE_BITS-1:0] cfg_lines,
    output logic [LINE_BITS-1:0] linecnt,
    output logic [3:0]           burst_idx,
    output logic [COL_BITS-1:0]  col
);

    logic [LINE_BITS-1:0] linecnt_q, linecnt_d;
    logic [3:0]           bidx_q, bidx_d;
    logic [COL_BITS-1:0]  col_q, col_d;

    always_comb begin
        linecnt_d = linecnt_q;
        bidx_d    = bidx_q;
        col_d     = col_q;
        // Vertical sync low wins over the end-of-line advance.
        if (!vs_sync) begin
            linecnt_d = '0;
        end else if (line_end) begin
            linecnt_d = (linecnt_q == cfg_lines) ? '0 : linecnt_q + 1'b1;
        end
        if (clr_burst) begin
            bidx_d = '0;
            col_d  = '0;
        end else if (burst_end) begin
            bidx_d = bidx_q + 4'd1;
            col_d  = col_q + cfg_stride;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            linecnt_q <= '0;
            bidx_q    <= '0;
            col_q     <= '0;
        end else begin
            linecnt_q <= linecnt_d;
            bidx_q    <= bidx_d;
            col_q     <= col_d;
        end
    end

    assign linecnt   = linecnt_q;
    assign burst_idx = bidx_q;
    assign col       = col_q;

endmodule

// File: rtl/rd_line_fetch.sv
// Fetches one video line from an MCB read port as cfg_nbrst bursts of cfg_bl+1 words.
// Read data is forwarded to the downstream buffer combinationally while in DATA.
module rd_line_fetch
    import rd_fetch_pkg::*;
#(
    parameter int DWIDTH    = 128,
    parameter int FB_BITS   = 2,
    parameter int LINE_BITS = 11,
    parameter int COL_BITS  = 13
) (
    input  logic                 memclk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 done,
    output logic                 busy,
    input  logic                 vs_sync,
    input  logic [FB_BITS-1:0]   frame_sel,
    input  logic [5:0]           cfg_bl,
    input  logic [3:0]           cfg_nbrst,
    input  logic [LINE_BITS-1:0] cfg_lines,
    input  logic [COL_BITS-1:0]  cfg_stride,
    input  logic                 arb_grant,
    input  logic                 out_afull,
    output logic                 mcb_cmd_en,
    output logic [2:0]           mcb_cmd_instr,
    output logic [5:0]           mcb_cmd_bl,
    output logic [29:0]          mcb_cmd_byte_addr,
    input  logic                 mcb_cmd_full,
    output logic                 mcb_rd_en,
    input  logic [DWIDTH-1:0]    mcb_rd_data,
    input  logic                 mcb_rd_empty,
    input  logic                 mcb_rd_full,
    input  logic [6:0]           mcb_rd_count,
    output logic                 out_valid,
    output logic [DWIDTH-1:0]    out_data,
    output logic                 err_ovf
);

    state_e               state_q, state_d;
    logic [5:0]           bl_q;
    logic [3:0]           nbrst_q;
    logic [LINE_BITS-1:0] lines_q;
    logic [COL_BITS-1:0]  stride_q;
    logic [5:0]           wcnt_q, wcnt_d;
    logic                 cmd_en_q;
    logic [29:0]          addr_q;
    logic                 ovf_q;

    logic                 start_fire, issue_fire, last_pop, line_done, pop, more_bursts;
    logic [3:0]           nbrst_eff;
    logic [LINE_BITS-1:0] linecnt;
    logic [3:0]           burst_idx;
    logic [COL_BITS-1:0]  col;

    rd_fetch_addr #(
        .LINE_BITS (LINE_BITS),
        .COL_BITS  (COL_BITS)
    ) u_addr (
        .clk        (memclk),
        .rst        (rst),
        .clr_burst  (state_q == ST_IDLE),
        .burst_end  (last_pop),
        .line_end   (line_done),
        .vs_sync    (vs_sync),
        .cfg_stride (stride_q),
        .cfg_lines  (lines_q),
        .linecnt    (linecnt),
        .burst_idx  (burst_idx),
        .col        (col)
    );

    assign nbrst_eff   = (nbrst_q == 4'd0) ? 4'd1 : nbrst_q;
    assign more_bursts = burst_idx < nbrst_eff;
    assign pop         = mcb_rd_en && !mcb_rd_empty;

    always_comb begin
        state_d    = state_q;
        start_fire = 1'b0;
        issue_fire = 1'b0;
        last_pop   = 1'b0;
        line_done  = 1'b0;
        mcb_rd_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_ISSUE;
                    start_fire = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (arb_grant && !mcb_cmd_full && !out_afull) begin
                    state_d    = ST_CMD;
                    issue_fire = 1'b1;
                end
            end
            ST_CMD: begin
                if (!mcb_rd_empty && (mcb_rd_count >= rd_threshold(bl_q))) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                mcb_rd_en = 1'b1;
                if (pop && (wcnt_q == bl_q)) begin
                    last_pop = 1'b1;
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (more_bursts) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d   = ST_IDLE;
                    line_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wcnt_d = '0;
        if (state_q == ST_DATA) begin
            wcnt_d = pop ? wcnt_q + 6'd1 : wcnt_q;
        end
    end

    always_ff @(posedge memclk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= '0;
            cmd_en_q <= 1'b0;
            addr_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            cmd_en_q <= issue_fire;
            if (issue_fire) begin
                addr_q <= 30'({frame_sel, linecnt, col});
            end
            // A full read FIFO in the same cycle as a new start still flags.
            if (mcb_rd_full) begin
                ovf_q <= 1'b1;
            end else if (start_fire) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Line configuration is frozen for the whole line.
    always_ff @(posedge memclk) begin
        if (start_fire) begin
            bl_q     <= cfg_bl;
            nbrst_q  <= cfg_nbrst;
            lines_q  <= cfg_lines;
            stride_q <= cfg_stride;
        end
    end

    assign done              = line_done;
    assign busy              = (state_q != ST_IDLE);
    assign mcb_cmd_en        = cmd_en_q;
    assign mcb_cmd_instr     = MCB_CMD_READ;
    assign mcb_cmd_bl        = bl_q;
    assign mcb_cmd_byte_addr = addr_q;
    assign out_valid         = (state_q == ST_DATA) && !mcb_rd_empty;
    assign out_data          = mcb_rd_data;
    assign err_ovf           = ovf_q;

endmodule

// File: tb/tb_rd_line_fetch.sv
// Scoreboard bench for rd_line_fetch: an MCB read-port model feeds data, expected
// commands and beats are queued at stimulus time and checked by a separate monitor.
module tb_rd_line_fetch;

    localparam int DW = 128;

    logic          memclk = 1'b0;
    logic          rst, start, vs_sync;
    logic [1:0]    frame_sel;
    logic [5:0]    cfg_bl;
    logic [3:0]    cfg_nbrst;
    logic [10:0]   cfg_lines;
    logic [12:0]   cfg_stride;
    logic          arb_grant, out_afull, mcb_cmd_full, mcb_rd_full;
    logic          mcb_rd_empty;
    logic [6:0]    mcb_rd_count;
    logic [DW-1:0] mcb_rd_data;
    logic          done, busy, mcb_cmd_en, mcb_rd_en, out_valid, err_ovf;
    logic [2:0]    mcb_cmd_instr;
    logic [5:0]    mcb_cmd_bl;
    logic [29:0]   mcb_cmd_byte_addr;
    logic [DW-1:0] out_data;

    int checks = 0;
    int errors = 0;
    int beats  = 0;
    int cmds   = 0;
    int dones  = 0;

    logic [DW-1:0] rdq[$];
    logic [DW-1:0] pend[$];
    logic [DW-1:0] exp_data[$];
    logic [29:0]   exp_addr[$];
    logic [5:0]    exp_bl[$];
    int            cap = 64;
    logic [5:0]    model_bl = 6'd0;
    logic          flush_req = 1'b0;

    always #5 memclk = ~memclk;

    rd_line_fetch dut (
        .memclk            (memclk),
        .rst               (rst),
        .start             (start),
        .done              (done),
        .busy              (busy),
        .vs_sync           (vs_sync),
        .frame_sel         (frame_sel),
        .cfg_bl            (cfg_bl),
        .cfg_nbrst         (cfg_nbrst),
        .cfg_lines         (cfg_lines),
        .cfg_stride        (cfg_stride),
        .arb_grant         (arb_grant),
        .out_afull         (out_afull),
        .mcb_cmd_en        (mcb_cmd_en),
        .mcb_cmd_instr     (mcb_cmd_instr),
        .mcb_cmd_bl        (mcb_cmd_bl),
        .mcb_cmd_byte_addr (mcb_cmd_byte_addr),
        .mcb_cmd_full      (mcb_cmd_full),
        .mcb_rd_en         (mcb_rd_en),
        .mcb_rd_data       (mcb_rd_data),
        .mcb_rd_empty      (mcb_rd_empty),
        .mcb_rd_full       (mcb_rd_full),
        .mcb_rd_count      (mcb_rd_count),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .err_ovf           (err_ovf)
    );

    function automatic logic [DW-1:0] mkword(input int s);
        return {32'(s), ~32'(s), 32'(s * 3 + 1), 32'hC0DE_0000 ^ 32'(s)};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // MCB read port: inputs change on the falling edge, one word enters the FIFO per cycle.
    initial begin
        int   seq;
        logic pop_prev;
        seq          = 0;
        pop_prev     = 1'b0;
        mcb_rd_empty = 1'b1;
        mcb_rd_count = '0;
        mcb_rd_data  = '0;
        forever begin
            @(negedge memclk);
            if (flush_req) begin
                rdq.delete();
                pend.delete();
                exp_data.delete();
                pop_prev  = 1'b0;
                flush_req = 1'b0;
            end
            if (pop_prev && rdq.size() > 0) rdq.delete(0);
            if (mcb_cmd_en) begin
                for (int i = 0; i <= int'(model_bl); i++) begin
                    pend.push_back(mkword(seq));
                    exp_data.push_back(mkword(seq));
                    seq++;
                end
            end
            if (pend.size() > 0 && rdq.size() < cap) rdq.push_back(pend.pop_front());
            mcb_rd_empty = (rdq.size() == 0);
            mcb_rd_count = 7'(rdq.size());
            mcb_rd_data  = (rdq.size() == 0) ? '0 : rdq[0];
            pop_prev     = mcb_rd_en && (rdq.size() > 0);
        end
    end

    // Monitor: compares every command and beat the DUT presents against the queues.
    initial begin
        forever begin
            @(negedge memclk);
            #2;
            if (mcb_cmd_en === 1'b1) begin
                cmds++;
                if (exp_addr.size() == 0) begin
                    check("cmd_unexpected", 1, 0);
                end else begin
                    check("cmd_addr", mcb_cmd_byte_addr, exp_addr.pop_front());
                    check("cmd_bl", mcb_cmd_bl, exp_bl.pop_front());
                    check("cmd_instr", mcb_cmd_instr, 3'b011);
                end
            end
            if (out_valid === 1'b1) begin
                beats++;
                if (exp_data.size() == 0) check("beat_unexpected", 1, 0);
                else check("out_data", out_data, exp_data.pop_front());
            end
            if (done === 1'b1) dones++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge memclk);
    endtask

    task automatic expect_raw(input logic [29:0] a, input logic [5:0] bl);
        exp_addr.push_back(a);
        exp_bl.push_back(bl);
    endtask

    task automatic expect_cmd(input logic [1:0] fs, input int line, input int col, input logic [5:0] bl);
        expect_raw(30'({fs, 11'(line), 13'(col)}), bl);
    endtask

    task automatic launch(input logic [1:0] fs, input logic [5:0] bl, input logic [3:0] nb,
                          input logic [12:0] st);
        @(negedge memclk);
        frame_sel  = fs;
        cfg_bl     = bl;
        cfg_nbrst  = nb;
        cfg_stride = st;
        model_bl   = bl;
        start      = 1'b1;
        @(negedge memclk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        int n;
        d0 = dones;
        n  = 0;
        while (dones == d0 && n < budget) begin
            @(negedge memclk);
            n++;
        end
        cyc(2);
        check({name, "_done_pulses"}, dones - d0, 1);
    endtask

    task automatic run_line(input string name, input logic [1:0] fs, input int line,
                            input logic [5:0] bl, input logic [3:0] nb, input logic [12:0] st);
        int nbe;
        nbe = (nb == 0) ? 1 : int'(nb);
        for (int i = 0; i < nbe; i++) expect_cmd(fs, line, (i * int'(st)) % 8192, bl);
        launch(fs, bl, nb, st);
        wait_done(name, 3000);
        check({name, "_cmds_left"}, exp_addr.size(), 0);
        check({name, "_data_left"}, exp_data.size(), 0);
    endtask

    initial begin
        int b0;
        int c0;
        int n;
        rst          = 1'b1;
        start        = 1'b0;
        vs_sync      = 1'b1;
        frame_sel    = '0;
        cfg_bl       = '0;
        cfg_nbrst    = 4'd1;
        cfg_lines    = 11'd899;
        cfg_stride   = '0;
        arb_grant    = 1'b1;
        out_afull    = 1'b0;
        mcb_cmd_full = 1'b0;
        mcb_rd_full  = 1'b0;

        cyc(3);
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cmd_en", mcb_cmd_en, 0);
        check("rst_rd_en", mcb_rd_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_err_ovf", err_ovf, 0);
        check("rst_addr", mcb_cmd_byte_addr, 0);
        @(negedge memclk);
        rst = 1'b0;
        cyc(2);

        // Lines 0..4 as single one-word bursts; line 0 uses nbrst=0 (acts as 1).
        run_line("nbrst0", 2'd1, 0, 6'd0, 4'd0, 13'd0);
        for (int l = 1; l < 5; l++) run_line("warm", 2'd1, l, 6'd0, 4'd1, 13'd0);

        // Full 4x60-word line at frame 1, line 5.
        expect_raw(30'h100A000, 6'd59);
        expect_raw(30'h100A3C0, 6'd59);
        expect_raw(30'h100A780, 6'd59);
        expect_raw(30'h100AB40, 6'd59);
        b0 = beats;
        c0 = cmds;
        launch(2'd1, 6'd59, 4'd4, 13'd960);
        wait_done("big_line", 3000);
        check("big_beats", beats - b0, 240);
        check("big_cmds", cmds - c0, 4);
        check("big_data_left", exp_data.size(), 0);

        // Short bursts with a read FIFO that never holds more than 4 words; a start while busy is dropped.
        cap = 4;
        expect_cmd(2'd2, 6, 0, 6'd3);
        expect_cmd(2'd2, 6, 100, 6'd3);
        b0 = beats;
        c0 = cmds;
        launch(2'd2, 6'd3, 4'd2, 13'd100);
        cyc(3);
        start = 1'b1;
        @(negedge memclk);
        start = 1'b0;
        wait_done("short_burst", 1000);
        check("short_beats", beats - b0, 8);
        cyc(5);
        #3;
        check("busy_start_ignored", busy, 0);
        check("short_cmds", cmds - c0, 2);
        cap = 64;

        // Downstream almost-full holds the command back.
        out_afull = 1'b1;
        expect_cmd(2'd0, 7, 0, 6'd0);
        c0 = cmds;
        launch(2'd0, 6'd0, 4'd1, 13'd0);
        cyc(50);
        check("afull_no_cmd", cmds - c0, 0);
        check("afull_busy", busy, 1);
        out_afull = 1'b0;
        @(negedge memclk);
        #3;
        check("afull_cmd_next", cmds - c0, 1);
        wait_done("afull", 200);

        // Sticky overflow flag, cleared by the next accepted start.
        @(negedge memclk);
        mcb_rd_full = 1'b1;
        @(negedge memclk);
        mcb_rd_full = 1'b0;
        #3;
        check("ovf_set", err_ovf, 1);
        cyc(5);
        #3;
        check("ovf_hold", err_ovf, 1);
        run_line("ovf_line", 2'd0, 8, 6'd0, 4'd1, 13'd0);
        check("ovf_cleared", err_ovf, 0);

        // Walk up to line 899, then the wrap back to line 0.
        for (int l = 9; l <= 899; l++) run_line("walk", 2'd3, l, 6'd0, 4'd1, 13'd0);
        run_line("wrap", 2'd3, 0, 6'd0, 4'd1, 13'd0);

        // vs_sync low in the done cycle must win over the increment.
        expect_cmd(2'd0, 1, 0, 6'd0);
        launch(2'd0, 6'd0, 4'd1, 13'd0);
        n = 0;
        while (n < 200) begin
            @(negedge memclk);
            #1;
            n++;
            if (done === 1'b1) break;
        end
        check("prio_done_seen", done, 1);
        vs_sync = 1'b0;
        @(negedge memclk);
        vs_sync = 1'b1;
        cyc(2);
        run_line("prio_after", 2'd0, 0, 6'd0, 4'd1, 13'd0);

        // Reset in the middle of a data burst.
        expect_cmd(2'd3, 1, 0, 6'd59);
        b0 = beats;
        launch(2'd3, 6'd59, 4'd1, 13'd0);
        n = 0;
        while (beats < b0 + 10 && n < 500) begin
            @(negedge memclk);
            n++;
        end
        check("mid_burst_reached", (beats >= b0 + 10), 1);
        rst = 1'b1;
        @(negedge memclk);
        rst       = 1'b0;
        flush_req = 1'b1;
        #3;
        check("midrst_busy", busy, 0);
        check("midrst_rd_en", mcb_rd_en, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_addr", mcb_cmd_byte_addr, 0);
        cyc(3);
        run_line("after_rst", 2'd3, 0, 6'd1, 4'd1, 13'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
